// File: rtl/sobel_line_packer.sv
// sobel_line_packer
//   Packs the 1-bit Sobel edge stream into bytes (first pixel of a group in
//   bit 7). Complete lines go into a two-bank ping-pong line buffer. Each
//   buffered line is sent over a valid/ready byte stream as one payload:
//   a 2-byte big-endian line number followed by IMAGE_WIDTH/8 packed bytes.
//
// Ports
//   clk          pixel-domain clock, all logic on rising edge
//   rst_p        synchronous active-high reset
//   sobel        edge pixel (1 = edge), qualified by sobel_valid
//   sobel_valid  pixel qualifier
//   sobel_hsync  line-active strobe; a falling edge ends a line
//   sobel_vsync  frame sync; a rising edge starts a frame
//   tx_data      payload byte
//   tx_valid     tx_data valid
//   tx_ready     consumer accepts the byte
//   tx_first     first payload byte (line-number high byte)
//   tx_last      final payload byte
//   overflow     sticky line-dropped flag, cleared at frame start
module sobel_line_packer #(
  parameter int IMAGE_WIDTH  = 1280,
  parameter int IMAGE_HEIGHT = 720
) (
  input  logic       clk,
  input  logic       rst_p,
  input  logic       sobel,
  input  logic       sobel_valid,
  input  logic       sobel_hsync,
  input  logic       sobel_vsync,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_first,
  output logic       tx_last,
  output logic       overflow
);

  localparam int BYTES = IMAGE_WIDTH / 8;
  localparam int PW    = $clog2(IMAGE_WIDTH);
  localparam int AW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, HDR_HI, HDR_LO, DATA} state_t;

  // Writer state
  logic          vs_d, hs_d;
  logic [PW-1:0] pix_cnt;
  logic [15:0]   line_cnt;
  logic [6:0]    sh;
  logic          wr_bank;
  logic          drop;
  logic [1:0]    bank_full, bank_full_nxt;
  logic [15:0]   bank_line [0:1];
  logic [7:0]    mem [0:1][0:BYTES-1];

  // Reader state
  state_t        state;
  logic          rd_bank, rd_next;
  logic [AW-1:0] rd_addr, addr_nxt;
  logic          bank_nxt;
  logic [7:0]    rd_q;

  logic vs_rise, hs_fall, adv, free_now, tgt_full, first_pix, drop_now;
  logic accept, byte_done, line_done, commit;

  assign vs_rise   = sobel_vsync & ~vs_d;
  assign hs_fall   = ~sobel_hsync & hs_d;
  assign adv       = tx_valid & tx_ready;
  assign free_now  = (state == DATA) & adv & tx_last;
  // A bank released by the reader this cycle is already usable by the writer.
  assign tgt_full  = bank_full[wr_bank] & ~(free_now & (rd_bank == wr_bank));
  assign first_pix = (pix_cnt == '0);
  // The drop decision is taken on a line's first pixel and held for the line.
  assign drop_now  = first_pix ? tgt_full : drop;
  // Frame start and short-line abort both take precedence over the pixel.
  assign accept    = sobel_valid & ~vs_rise & ~(hs_fall & ~first_pix) &
                     (line_cnt < 16'(IMAGE_HEIGHT));
  assign byte_done = accept & (pix_cnt[2:0] == 3'd7);
  assign line_done = accept & (pix_cnt == PW'(IMAGE_WIDTH - 1));
  assign commit    = line_done & ~drop_now;

  always_comb begin
    bank_full_nxt = bank_full;
    if (free_now) bank_full_nxt[rd_bank] = 1'b0;
    if (commit)   bank_full_nxt[wr_bank] = 1'b1;
  end

  // ---- write side: edge detect, pixel/line counting, bank bookkeeping ----
  always_ff @(posedge clk) begin
    if (rst_p) begin
      vs_d      <= 1'b0;
      hs_d      <= 1'b0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      wr_bank   <= 1'b0;
      drop      <= 1'b0;
      overflow  <= 1'b0;
      bank_full <= 2'b00;
    end else begin
      vs_d      <= sobel_vsync;
      hs_d      <= sobel_hsync;
      bank_full <= bank_full_nxt;
      if (vs_rise) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
        drop     <= 1'b0;
        overflow <= 1'b0;
      end else if (hs_fall && !first_pix) begin
        pix_cnt  <= '0;
        line_cnt <= line_cnt + 16'd1;
        drop     <= 1'b0;
      end else if (accept) begin
        if (first_pix) begin
          drop <= tgt_full;
          if (tgt_full) overflow <= 1'b1;
        end
        if (line_done) begin
          pix_cnt  <= '0;
          line_cnt <= line_cnt + 16'd1;
          drop     <= 1'b0;
          // A dropped line leaves the pointer on the still-full bank.
          if (!drop_now) wr_bank <= ~wr_bank;
        end else begin
          pix_cnt <= pix_cnt + PW'(1);
        end
      end
    end
  end

  // ---- write side: shift register and line buffer storage ----
  always_ff @(posedge clk) begin
    if (accept)                 sh <= {sh[5:0], sobel};
    if (byte_done && !drop_now) mem[wr_bank][pix_cnt[PW-1:3]] <= {sh, sobel};
    if (commit)                 bank_line[wr_bank] <= line_cnt;
  end

  // Read address for the next cycle; rd_q always holds mem[rd_bank][rd_addr].
  always_comb begin
    bank_nxt = rd_bank;
    addr_nxt = rd_addr;
    if (state == IDLE) begin
      bank_nxt = rd_next;
      addr_nxt = '0;
    end else if (adv && ((state == HDR_LO) ||
                         ((state == DATA) && (rd_addr != AW'(BYTES - 1))))) begin
      addr_nxt = rd_addr + AW'(1);
    end
  end

  // ---- read side: prefetch register ----
  always_ff @(posedge clk) begin
    rd_q <= mem[bank_nxt][addr_nxt];
  end

  // ---- read side: payload FSM with registered outputs ----
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state    <= IDLE;
      rd_bank  <= 1'b0;
      rd_next  <= 1'b0;
      rd_addr  <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      tx_first <= 1'b0;
      tx_last  <= 1'b0;
    end else begin
      rd_addr <= addr_nxt;
      case (state)
        IDLE: begin
          // Banks fill in strict alternation, so rd_next is always the oldest.
          if (bank_full[rd_next]) begin
            rd_bank  <= rd_next;
            rd_next  <= ~rd_next;
            tx_data  <= bank_line[rd_next][15:8];
            tx_valid <= 1'b1;
            tx_first <= 1'b1;
            tx_last  <= 1'b0;
            state    <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (adv) begin
            tx_data  <= bank_line[rd_bank][7:0];
            tx_first <= 1'b0;
            state    <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (adv) begin
            tx_data <= rd_q;
            tx_last <= (rd_addr == AW'(BYTES - 1));
            state   <= DATA;
          end
        end
        DATA: begin
          if (adv) begin
            if (tx_last) begin
              tx_data  <= 8'h00;
              tx_valid <= 1'b0;
              tx_last  <= 1'b0;
              state    <= IDLE;
            end else begin
              tx_data <= rd_q;
              tx_last <= (rd_addr == AW'(BYTES - 1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_line_packer.sv
module tb_sobel_line_packer;
  localparam int W  = 1280;
  localparam int H  = 6;
  localparam int NB = W / 8;

  logic       clk = 1'b0;
  logic       rst_p, sobel, sobel_valid, sobel_hsync, sobel_vsync, tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_first, tx_last, overflow;

  sobel_line_packer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk(clk), .rst_p(rst_p), .sobel(sobel), .sobel_valid(sobel_valid),
    .sobel_hsync(sobel_hsync), .sobel_vsync(sobel_vsync),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_first(tx_first), .tx_last(tx_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected byte stream {first,last,data}, line numbering,
  // and bank occupancy as committed-minus-sent payload counts.
  logic [9:0] exp_q[$];
  int  mdl_line  = 0;
  int  committed = 0;
  int  sent      = 0;
  bit  mdl_ovf   = 0;
  bit  pix [W];
  int  rdy_mode  = 0;
  bit  mon_en    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen(input int mode, input int k);
    for (int n = 0; n < W; n++) begin
      case (mode)
        0:       pix[n] = (n % 2 == 0);
        1:       pix[n] = (n == k);
        default: pix[n] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic push_payload(input int line);
    logic [15:0] ln;
    logic [7:0]  b;
    ln = 16'(line);
    exp_q.push_back({1'b1, 1'b0, ln[15:8]});
    exp_q.push_back({1'b0, 1'b0, ln[7:0]});
    for (int j = 0; j < NB; j++) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) b = b | (8'(pix[8*j+i]) << (7 - i));
      exp_q.push_back({1'b0, (j == NB - 1), b});
    end
  endtask

  task automatic drive_line(input int npix, input int gap);
    bit ign, drp;
    ign = (mdl_line >= H);
    drp = 0;
    sobel_hsync = 1'b1;
    for (int n = 0; n < npix; n++) begin
      sobel = pix[n];
      sobel_valid = 1'b1;
      tick();
      if (n == 0 && !ign) drp = ((committed - sent) >= 2);
    end
    sobel_valid = 1'b0;
    sobel = 1'b0;
    sobel_hsync = 1'b0;
    if (!ign) begin
      if (npix == W && !drp) begin
        push_payload(mdl_line);
        committed++;
      end
      if (drp) mdl_ovf = 1;
      mdl_line++;
    end
    repeat (gap) tick();
  endtask

  task automatic vsync_pulse();
    sobel_vsync = 1'b1;
    tick();
    tick();
    sobel_vsync = 1'b0;
    tick();
    mdl_line = 0;
    mdl_ovf = 0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || tx_valid) && c < budget) begin
      tick();
      c++;
    end
    check("drain_within_budget", 32'(c < budget), 32'd1);
  endtask

  // Consumer ready pattern
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: scoreboard, stall stability and no mid-payload gaps
  initial begin
    logic [10:0] prev;
    logic [9:0]  e;
    bit prev_stall, in_pay;
    prev = '0;
    prev_stall = 0;
    in_pay = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_stall = 0;
        in_pay = 0;
      end else begin
        if (prev_stall)
          check("stall_hold", 32'({tx_valid, tx_first, tx_last, tx_data}), 32'(prev));
        if (in_pay) check("valid_mid_payload", 32'(tx_valid), 32'd1);
        if (tx_valid && tx_ready) begin
          check("byte_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("byte", 32'({tx_first, tx_last, tx_data}), 32'(e));
          end
          if (tx_last) sent++;
          in_pay = !tx_last;
        end
        prev_stall = tx_valid && !tx_ready;
        prev = {tx_valid, tx_first, tx_last, tx_data};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_p = 1'b1; sobel = 1'b0; sobel_valid = 1'b0;
    sobel_hsync = 1'b0; sobel_vsync = 1'b0;
    repeat (3) tick();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data",  32'(tx_data),  32'd0);
    check("rst_tx_first", 32'(tx_first), 32'd0);
    check("rst_tx_last",  32'(tx_last),  32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst_p = 1'b0;
    mon_en = 1;

    // Alternating 1,0 line with ready high
    rdy_mode = 1;
    gen(0, 0);
    drive_line(W, 0);
    tick();
    tick();
    check("hdr_latency_valid", 32'(tx_valid), 32'd1);
    drain(5000);

    // Frame start, three single-edge lines
    vsync_pulse();
    for (int k = 0; k < 3; k++) begin
      gen(1, k);
      drive_line(W, 20);
    end
    drain(5000);

    // Random stalls over two random lines
    rdy_mode = 2;
    for (int k = 0; k < 2; k++) begin
      gen(2, 0);
      drive_line(W, 20);
    end
    drain(5000);
    rdy_mode = 1;

    // Consumer blocked for three lines: third line dropped
    rdy_mode = 0;
    vsync_pulse();
    for (int k = 0; k < 3; k++) begin
      gen(2, 0);
      drive_line(W, 20);
    end
    check("overflow_set", 32'(overflow), 32'(mdl_ovf));
    rdy_mode = 1;
    drain(5000);
    gen(2, 0);
    drive_line(W, 20);
    drain(5000);
    check("overflow_sticky", 32'(overflow), 32'(mdl_ovf));

    // Short line then full line
    vsync_pulse();
    check("overflow_cleared", 32'(overflow), 32'd0);
    gen(2, 0);
    drive_line(W / 2, 10);
    gen(2, 0);
    drive_line(W, 10);
    drain(5000);

    // Frame start in the middle of line 5
    vsync_pulse();
    for (int k = 0; k < 5; k++) begin
      gen(2, 0);
      drive_line(16, 4);
    end
    gen(2, 0);
    sobel_hsync = 1'b1;
    for (int n = 0; n < 300; n++) begin
      sobel = pix[n];
      sobel_valid = 1'b1;
      tick();
    end
    sobel_valid = 1'b0;
    vsync_pulse();
    sobel_hsync = 1'b0;
    repeat (4) tick();
    gen(2, 0);
    drive_line(W, 10);
    drain(5000);
    check("overflow_after_restart", 32'(overflow), 32'd0);

    // Overlong frame: lines beyond the height are ignored
    vsync_pulse();
    for (int k = 0; k < H; k++) begin
      gen(2, 0);
      drive_line(16, 4);
    end
    gen(2, 0);
    drive_line(W, 20);
    drain(5000);
    check("overlong_idle", 32'(tx_valid), 32'd0);

    // Reset in the middle of a payload
    vsync_pulse();
    gen(2, 0);
    drive_line(W, 0);
    repeat (20) tick();
    check("payload_in_progress", 32'(tx_valid), 32'd1);
    mon_en = 0;
    rst_p = 1'b1;
    tick();
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_tx_data",  32'(tx_data),  32'd0);
    check("midrst_tx_first", 32'(tx_first), 32'd0);
    check("midrst_tx_last",  32'(tx_last),  32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    rst_p = 1'b0;
    exp_q.delete();
    committed = 0;
    sent = 0;
    mdl_line = 0;
    mdl_ovf = 0;
    tick();
    mon_en = 1;
    gen(2, 0);
    drive_line(W, 10);
    drain(5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
